// File: rtl/uart_tx.sv
// UART transmitter: serializes one NB_DATA-bit word per request into an
// LSB-first frame (start, data, optional even parity, stop) paced by a 16x
// baud strobe. Define UART_TX_PARITY_EN to add the even-parity bit.
module uart_tx #(
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned NB_STOP_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int unsigned BitW  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam int unsigned StopW = (NB_STOP_TICKS > 1) ? $clog2(NB_STOP_TICKS) : 1;
    localparam logic [BitW-1:0]  LastBit  = BitW'(NB_DATA - 1);
    localparam logic [StopW-1:0] LastStop = StopW'(NB_STOP_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e             state_q;
    logic [3:0]         tick_cnt_q;
    logic [BitW-1:0]    bit_cnt_q;
    logic [StopW-1:0]   stop_cnt_q;
    logic [NB_DATA-1:0] shift_q;
    logic [NB_DATA-1:0] shift_d;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
`endif

    // Shift register contents after the current data bit is retired.
    always_comb begin
        shift_d = shift_q >> 1;
    end

    // Frame sequencer; the line level is computed on each transition so o_tx
    // comes straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    // busy_q is still high during the done cycle; requests there are dropped.
                    if (i_tx_start && !done_q) begin
                        shift_q    <= i_tx_data;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStart;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^i_tx_data;
`endif
                    end
                end
                StStart: begin
                    if (i_tick) begin
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= '0;
                            tx_q       <= shift_q[0];
                            state_q    <= StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (i_tick) begin
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_d;
                            if (bit_cnt_q == LastBit) begin
                                bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                                tx_q      <= parity_q;
                                state_q   <= StParity;
`else
                                tx_q      <= 1'b1;
                                state_q   <= StStop;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                tx_q      <= shift_d[0];
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (i_tick) begin
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= '0;
                            tx_q       <= 1'b1;
                            state_q    <= StStop;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
`endif
                StStop: begin
                    if (i_tick) begin
                        if (stop_cnt_q == LastStop) begin
                            stop_cnt_q <= '0;
                            done_q     <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed and randomized frames checked against a
// per-tick line-level model and a mid-bit sampling receiver model.
module tb_uart_tx;

    localparam int NB   = 8;
    localparam int STOP = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TOTAL = 16 * (1 + NB) + STOP + 16 * PAR;
    localparam int NBITS = 1 + NB + PAR + 1;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_tick = 1'b0;
    logic          i_tx_start = 1'b0;
    logic [NB-1:0] i_tx_data = '0;
    logic          o_tx;
    logic          o_tx_busy;
    logic          o_tx_done;

    int checks = 0;
    int errors = 0;
    int tick_period = 1;
    int tick_ph = 0;
    int tick_seen = 0;
    int base = 0;

    uart_tx #(
        .NB_DATA      (NB),
        .NB_STOP_TICKS(STOP)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tick    (i_tick),
        .i_tx_start(i_tx_start),
        .i_tx_data (i_tx_data),
        .o_tx      (o_tx),
        .o_tx_busy (o_tx_busy),
        .o_tx_done (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    // Baud strobe: one pulse every tick_period cycles, changed on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (tick_period <= 1) begin
                i_tick = 1'b1;
            end else begin
                i_tick  = (tick_ph == 0);
                tick_ph = (tick_ph + 1) % tick_period;
            end
        end
    end

    // Count the strobes the DUT actually samples.
    always @(posedge i_clk) begin
        if (i_tick) tick_seen <= tick_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Expected line level k ticks into a frame carrying d.
    function automatic logic exp_level(input logic [NB-1:0] d, input int k);
        int b;
        b = k / 16;
        if (b == 0) return 1'b0;
        if (b <= NB) return d[b-1];
        if (PAR == 1 && b == NB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic start_frame(input logic [NB-1:0] d);
        int n;
        n = 0;
        while (o_tx_busy !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("idle_before_start", o_tx_busy, 0);
        i_tx_start = 1'b1;
        i_tx_data  = d;
        step();
        check("accept_tx_low", o_tx, 0);
        check("accept_busy", o_tx_busy, 1);
        i_tx_start = 1'b0;
        i_tx_data  = NB'($urandom);
        base       = tick_seen;
    endtask

    // mode 0: plain; 1: inject rejected requests mid-data and in the done
    // cycle; 2: raise the next request (nxt) in the done cycle.
    task automatic monitor(input logic [NB-1:0] d, input int mode, input logic [NB-1:0] nxt);
        int k;
        int cyc;
        int mism;
        int limit;
        bit fin;
        bit inj;
        logic rx[NBITS];
        bit got[NBITS];
        logic [NB-1:0] word;
        cyc   = 0;
        mism  = 0;
        fin   = 0;
        inj   = 0;
        limit = TOTAL * (tick_period < 1 ? 1 : tick_period) + 50;
        for (int i = 0; i < NBITS; i++) begin
            got[i] = 0;
            rx[i]  = 1'bx;
        end
        while (!fin && cyc < limit) begin
            k = tick_seen - base;
            if (k < TOTAL) begin
                if (o_tx !== exp_level(d, k)) mism++;
                if (o_tx_done !== 1'b0) mism++;
                if (o_tx_busy !== 1'b1) mism++;
                if (k % 16 == 8 && k / 16 < NBITS && !got[k/16]) begin
                    rx[k/16]  = o_tx;
                    got[k/16] = 1;
                end
                if (mode == 1 && k >= 72 && !inj) begin
                    i_tx_start = 1'b1;
                    i_tx_data  = 8'hF0;
                    inj        = 1;
                end else begin
                    i_tx_start = 1'b0;
                end
                step();
                cyc++;
            end else begin
                fin = 1;
                check("done_pulse", o_tx_done, 1);
                check("done_busy", o_tx_busy, 1);
                check("done_tx_high", o_tx, 1);
                if (mode != 0) begin
                    i_tx_start = 1'b1;
                    i_tx_data  = (mode == 1) ? 8'hF0 : nxt;
                end
            end
        end
        check("frame_end", fin, 1);
        check("wave_mismatches", mism, 0);
        for (int i = 0; i < NB; i++) word[i] = rx[i+1];
        check("rx_start", rx[0], 0);
        check("rx_data", word, d);
        check("rx_stop", rx[NBITS-1], 1);
    endtask

    task automatic after_done(input int mode);
        int mism;
        step();
        i_tx_start = 1'b0;
        check("post_busy_low", o_tx_busy, 0);
        check("post_done_low", o_tx_done, 0);
        check("post_tx_high", o_tx, 1);
        if (mode == 1) begin
            mism = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) mism++;
            end
            check("no_requeue", mism, 0);
        end
    endtask

    initial begin
        int n;
        int mism;
        logic [NB-1:0] d;

        // Reset held 3 cycles with a strobe every cycle.
        tick_period = 1;
        i_reset     = 1'b1;
        i_tx_start  = 1'b1;
        i_tx_data   = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", o_tx, 1);
            check("rst_busy", o_tx_busy, 0);
            check("rst_done", o_tx_done, 0);
        end
        i_tx_start = 1'b0;
        i_reset    = 1'b0;
        step();
        check("idle_tx", o_tx, 1);
        check("idle_busy", o_tx_busy, 0);

        // Single frame, strobe every cycle.
        start_frame(8'h55);
        monitor(8'h55, 0, 8'h00);
        after_done(0);

        // Realistic baud rate.
        tick_period = 163;
        start_frame(8'hA3);
        monitor(8'hA3, 0, 8'h00);
        after_done(0);
        tick_period = 1;

        // Requests while busy and in the done cycle are dropped.
        start_frame(8'h0F);
        monitor(8'h0F, 1, 8'h00);
        after_done(1);

        // Back-to-back frames.
        start_frame(8'h00);
        monitor(8'h00, 2, 8'hFF);
        step();
        check("b2b_gap_tx", o_tx, 1);
        check("b2b_gap_busy", o_tx_busy, 0);
        step();
        check("b2b_start_tx", o_tx, 0);
        check("b2b_start_busy", o_tx_busy, 1);
        i_tx_start = 1'b0;
        i_tx_data  = NB'($urandom);
        base       = tick_seen;
        monitor(8'hFF, 0, 8'h00);
        after_done(0);

        // Randomized words, strobe rates and idle gaps.
        for (int r = 0; r < 6; r++) begin
            tick_period = $urandom_range(1, 4);
            d = NB'($urandom);
            repeat ($urandom_range(0, 3)) step();
            start_frame(d);
            monitor(d, 0, 8'h00);
            after_done(0);
        end
        tick_period = 1;

        // Frame with parity-sensitive word (parity bit present only when enabled).
        start_frame(8'h07);
        monitor(8'h07, 0, 8'h00);
        after_done(0);

        // Reset during DATA abandons the frame.
        start_frame(8'h07);
        n = 0;
        while ((tick_seen - base) < 40 && n < 200) begin
            step();
            n++;
        end
        check("abort_reached_data", ((tick_seen - base) >= 40), 1);
        i_reset = 1'b1;
        step();
        check("abort_tx", o_tx, 1);
        check("abort_busy", o_tx_busy, 0);
        check("abort_done", o_tx_done, 0);
        i_reset = 1'b0;
        mism = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) mism++;
        end
        check("abort_no_done", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter that serializes one parallel data word per request into an LSB-first asynchronous frame on a single output line. Bit timing comes from the shared baud-rate tick generator's 16× oversampling strobe (`i_tick`), the same strobe that drives the UART receiver. The block sits between the user-side data interface (or FIFO) and the physical TX pin, and is the transmit counterpart of the receiver in the UART datapath.

## Interface

Parameters:
- `NB_DATA`, 8: data bits per frame.
- `NB_STOP_TICKS`, 16: stop-bit duration in ticks (16 = 1 stop bit, 32 = 2 stop bits).

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_tick`  in  1  16× baud strobe, one `i_clk` cycle wide.
- `i_tx_start`  in  1  transmit request; sampled only while idle.
- `i_tx_data`  in  NB_DATA  word to send; captured when a request is accepted.
- `o_tx`  out  1  serial line; idles high.
- `o_tx_busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `o_tx_done`  out  1  one-cycle pulse at the end of the stop bit.

## Operation

- FSM states: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- Registers:
  - 4-bit tick counter `tick_cnt`.
  - Data-bit counter sized clog2(NB_DATA) bits.
  - Stop-tick counter sized for NB_STOP_TICKS.
  - NB_DATA-bit shift register.
- IDLE:
  - `o_tx`=1 and `o_tx_busy`=0.
  - If `i_tx_start`=1, latch `i_tx_data` into the shift register, clear the counters, and move to START.
- START: `o_tx`=0. On an `i_tick` with `tick_cnt`==15, clear `tick_cnt` and move to DATA.
- DATA:
  - `o_tx` = shift register bit 0 (LSB first).
  - On an `i_tick` with `tick_cnt`==15: shift right and increment the bit counter.
  - After bit NB_DATA-1, move to PARITY (macro defined) or STOP (macro undefined).
- STOP:
  - `o_tx`=1.
  - On the NB_STOP_TICKS-th `i_tick` in STOP: pulse `o_tx_done` for that one cycle and move to IDLE.
- `tick_cnt` increments only on `i_tick`; cycles without `i_tick` hold all state.
- `tick_cnt` wraps 15→0 only at a bit boundary, never free-running.
- `i_tx_start` while busy, or in the cycle `o_tx_done` is high: ignored. There is no queueing; the requester must wait for `o_tx_busy`=0.
- `i_tx_data` changes after acceptance do not affect the frame in flight.
- `o_tx` is driven from a register, so it is glitch-free.

## Timing

- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0, state=IDLE, all counters 0, shift register 0.
- Reset asserted mid-frame:
  - Frame abandoned.
  - `o_tx`=1 from the next cycle.
  - No `o_tx_done`.
- Acceptance latency: request in cycle N gives `o_tx`=0 and `o_tx_busy`=1 in cycle N+1.
- Bit duration: exactly 16 `i_tick` pulses per start, data, and parity bit; NB_STOP_TICKS pulses for stop.
- Frame length in ticks:
  - 16·(1+NB_DATA) + NB_STOP_TICKS without the macro.
  - 16 more with UART_TX_PARITY_EN.
- Defaults: 160 ticks without parity, 176 with.
- `o_tx_done` and `o_tx_busy` fall together at the end of the frame. `o_tx_busy` is 0 in the cycle after the `o_tx_done` pulse.
- Back-to-back frames: the earliest next acceptance is the cycle after `o_tx_done`. That gives one idle-high cycle (not one bit time) between frames.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in.
  - It transmits the even-parity bit (XOR of the captured word) for 16 ticks between DATA and STOP.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.
- Must match the receiver's framing; the default build leaves it undefined.

## Test plan

- Reset: hold `i_reset` 3 cycles with `i_tick` every cycle. Expect `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0 throughout, with the FSM staying idle.
- Single frame, 0x55, `i_tick` every cycle, no parity:
  - `o_tx` = 0, then 1,0,1,0,1,0,1,0, then 1 (stop), each level held 16 cycles.
  - `o_tx_done` pulses once, 160 ticks after the start bit begins.
- Realistic baud, `i_tick` every 163 cycles, data 0xA3: the bench's UART receiver model decodes 0xA3 with a valid stop bit.
- Busy rejection:
  - Send 0x0F.
  - Assert `i_tx_start` with 0xF0 in mid-DATA and again in the `o_tx_done` cycle.
  - Expect only 0x0F transmitted and `o_tx_busy` low afterwards.
- Back-to-back: 0x00 then 0xFF, the second request held high from `o_tx_done`. Expect the second start bit to begin 2 cycles after the `o_tx_done` pulse.
- Abort plus parity:
  - With UART_TX_PARITY_EN, send 0x07: expect parity bit 1 for 16 ticks, total 176 ticks.
  - Assert `i_reset` during DATA: expect `o_tx`=1 next cycle and no `o_tx_done`.
